minibyte_bus_ctrl: RTL and testbench

- Parametrised external-bus controller for the next Minibyte generation.
- Sits between the CPU memory port and the chip pins. Supports CPU addresses wider than the 7 address pins by sending the address in two phases: upper bits on a latch strobe, then lower bits.
- Inserts programmable wait states and drives the bidirectional data-bus output enable only during the write data phase.
- Serves a region-mapped internal ROM with no external bus cycle.

---
 rtl/minibyte_bus_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_minibyte_bus_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/minibyte_bus_ctrl.sv
// -----------------------------------------------------------------------------
// minibyte_bus_ctrl
//
// External-bus controller that sits between the CPU memory port and the chip
// pins. A CPU address wider than the address pins is sent in two phases: first
// the upper bits with pin_ale_out high, then the lower bits. Programmable wait
// states separate the address and data phases. Accesses that fall in the
// region-mapped internal ROM are served without any external bus cycle.
//
// Every output is decoded from registered state only, so no input reaches an
// output combinationally.
//
// Ports
//   clk_in, rst_in       clock (rising edge), synchronous active-high reset
//   cpu_req_in           access request, sampled only in IDLE
//   cpu_we_in            1 = write, 0 = read, sampled with cpu_req_in
//   cpu_addr_in          access address (ADDR_W)
//   cpu_data_in          write data (DATA_W)
//   cpu_ack_out          one-cycle completion pulse
//   cpu_data_out         read data, held until the next read completes
//   busy_out             high in every state except IDLE
//   rom_en_in            1 = ROM region mapped in, sampled only in IDLE
//   rom_addr_out         internal ROM address
//   rom_data_in          combinational internal ROM data
//   pin_addr_out         multiplexed address pins
//   pin_ale_out          address-latch strobe, high in the upper-address phase
//   pin_we_out           external write enable
//   bus_data_in          data pins, input path
//   bus_data_out         data pins, output path
//   bus_oe_out           per-bit output enable (1 = drive)
// -----------------------------------------------------------------------------
module minibyte_bus_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int PIN_ADDR_W  = 7,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int ROM_ADDR_W  = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  cpu_req_in,
  input  logic                  cpu_we_in,
  input  logic [ADDR_W-1:0]     cpu_addr_in,
  input  logic [DATA_W-1:0]     cpu_data_in,
  output logic                  cpu_ack_out,
  output logic [DATA_W-1:0]     cpu_data_out,
  output logic                  busy_out,
  input  logic                  rom_en_in,
  output logic [ROM_ADDR_W-1:0] rom_addr_out,
  input  logic [DATA_W-1:0]     rom_data_in,
  output logic [PIN_ADDR_W-1:0] pin_addr_out,
  output logic                  pin_ale_out,
  output logic                  pin_we_out,
  input  logic [DATA_W-1:0]     bus_data_in,
  output logic [DATA_W-1:0]     bus_data_out,
  output logic [DATA_W-1:0]     bus_oe_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_HI,
    S_ADDR_LO,
    S_WAIT,
    S_DATA,
    S_ROM,
    S_ACK
  } state_e;

  // The upper-address phase only exists when the CPU address is wider than
  // the pins; the wait state only exists when wait cycles are configured.
  localparam bit         TWO_PHASE = (ADDR_W > PIN_ADDR_W);
  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_e              state_q,    state_d;
  logic [ADDR_W-1:0]   addr_q,     addr_d;
  logic                we_q,       we_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;

  logic                  rom_hit;
  logic [PIN_ADDR_W-1:0] addr_hi;
  logic [PIN_ADDR_W-1:0] addr_lo;

  // An address is in the ROM window when every bit above the ROM index is 0.
  // A shift keeps this legal even when the ROM spans the whole address space.
  assign rom_hit = ((cpu_addr_in >> ROM_ADDR_W) == '0);

  // Upper address is zero-extended to the pin width; a shift avoids a
  // reversed part-select when ADDR_W equals PIN_ADDR_W.
  assign addr_hi = PIN_ADDR_W'(addr_q >> PIN_ADDR_W);
  assign addr_lo = addr_q[PIN_ADDR_W-1:0];

  // ---------------------------------------------------------------------------
  // State and data registers
  // ---------------------------------------------------------------------------
  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    wait_cnt_d   = wait_cnt_q;

    cpu_ack_out  = 1'b0;
    rom_addr_out = '0;
    pin_addr_out = '0;
    pin_ale_out  = 1'b0;
    pin_we_out   = 1'b0;
    bus_data_out = '0;
    bus_oe_out   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req_in) begin
          addr_d  = cpu_addr_in;
          we_d    = cpu_we_in;
          wdata_d = cpu_data_in;
          if (rom_en_in && rom_hit) begin
            state_d = S_ROM;
          end else if (TWO_PHASE) begin
            state_d = S_ADDR_HI;
          end else begin
            state_d = S_ADDR_LO;
          end
        end
      end

      S_ADDR_HI: begin
        pin_addr_out = addr_hi;
        pin_ale_out  = 1'b1;
        state_d      = S_ADDR_LO;
      end

      S_ADDR_LO: begin
        pin_addr_out = addr_lo;
        if (HAS_WAIT) begin
          wait_cnt_d = WAIT_LOAD;
          state_d    = S_WAIT;
        end else begin
          state_d    = S_DATA;
        end
      end

      // The counter holds the number of wait cycles still to spend, including
      // the current one, so leaving at 1 gives exactly WAIT_STATES cycles.
      S_WAIT: begin
        pin_addr_out = addr_lo;
        if (wait_cnt_q == 4'd1) begin
          state_d = S_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      S_DATA: begin
        pin_addr_out = addr_lo;
        if (we_q) begin
          pin_we_out   = 1'b1;
          bus_oe_out   = {DATA_W{1'b1}};
          bus_data_out = wdata_q;
        end else begin
          rdata_d = bus_data_in;
        end
        state_d = S_ACK;
      end

      // ROM writes are dropped silently but still acknowledged.
      S_ROM: begin
        rom_addr_out = addr_q[ROM_ADDR_W-1:0];
        if (!we_q) begin
          rdata_d = rom_data_in;
        end
        state_d = S_ACK;
      end

      S_ACK: begin
        cpu_ack_out = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_out     = (state_q != S_IDLE);
  assign cpu_data_out = rdata_q;

endmodule

// File: tb/tb_minibyte_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_minibyte_bus_ctrl
//
// Directed bench for minibyte_bus_ctrl. Three instances share the clock, reset
// and data/address inputs, each with its own request line:
//   u0  defaults (ADDR_W=10, PIN_ADDR_W=7, WAIT_STATES=1)
//   u1  WAIT_STATES=0
//   u2  ADDR_W=PIN_ADDR_W=7, WAIT_STATES=3 (single-phase address)
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_minibyte_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req [3];
  logic       we;
  logic [9:0] addr;
  logic [7:0] wdata;
  logic       rom_en;
  logic [7:0] rom_data;
  logic [7:0] bus_din;

  logic       ack      [3];
  logic [7:0] cpu_dout [3];
  logic       busy     [3];
  logic [4:0] rom_addr [3];
  logic [6:0] pin_addr [3];
  logic       ale      [3];
  logic       pin_we   [3];
  logic [7:0] bus_dout [3];
  logic [7:0] bus_oe   [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  minibyte_bus_ctrl u0 (
    .clk_in(clk), .rst_in(rst), .cpu_req_in(req[0]), .cpu_we_in(we),
    .cpu_addr_in(addr), .cpu_data_in(wdata), .cpu_ack_out(ack[0]),
    .cpu_data_out(cpu_dout[0]), .busy_out(busy[0]), .rom_en_in(rom_en),
    .rom_addr_out(rom_addr[0]), .rom_data_in(rom_data),
    .pin_addr_out(pin_addr[0]), .pin_ale_out(ale[0]), .pin_we_out(pin_we[0]),
    .bus_data_in(bus_din), .bus_data_out(bus_dout[0]), .bus_oe_out(bus_oe[0])
  );

  minibyte_bus_ctrl #(.WAIT_STATES(0)) u1 (
    .clk_in(clk), .rst_in(rst), .cpu_req_in(req[1]), .cpu_we_in(we),
    .cpu_addr_in(addr), .cpu_data_in(wdata), .cpu_ack_out(ack[1]),
    .cpu_data_out(cpu_dout[1]), .busy_out(busy[1]), .rom_en_in(rom_en),
    .rom_addr_out(rom_addr[1]), .rom_data_in(rom_data),
    .pin_addr_out(pin_addr[1]), .pin_ale_out(ale[1]), .pin_we_out(pin_we[1]),
    .bus_data_in(bus_din), .bus_data_out(bus_dout[1]), .bus_oe_out(bus_oe[1])
  );

  minibyte_bus_ctrl #(.ADDR_W(7), .WAIT_STATES(3)) u2 (
    .clk_in(clk), .rst_in(rst), .cpu_req_in(req[2]), .cpu_we_in(we),
    .cpu_addr_in(addr[6:0]), .cpu_data_in(wdata), .cpu_ack_out(ack[2]),
    .cpu_data_out(cpu_dout[2]), .busy_out(busy[2]), .rom_en_in(rom_en),
    .rom_addr_out(rom_addr[2]), .rom_data_in(rom_data),
    .pin_addr_out(pin_addr[2]), .pin_ale_out(ale[2]), .pin_we_out(pin_we[2]),
    .bus_data_in(bus_din), .bus_data_out(bus_dout[2]), .bus_oe_out(bus_oe[2])
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    we       = 1'b0;
    addr     = '0;
    wdata    = '0;
    rom_en   = 1'b0;
    rom_data = '0;
    bus_din  = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_busy",  busy[0],     0);
    check("rst_ack",   ack[0],      0);
    check("rst_paddr", pin_addr[0], 0);
    check("rst_oe",    bus_oe[0],   0);
    check("rst_dout",  cpu_dout[0], 0);
    step();

    // External read at defaults: addr 0x2A5 -> hi 0x05, lo 0x25
    addr = 10'h2A5; we = 1'b0; bus_din = 8'h3C; req[0] = 1'b1;
    step();
    check("rd_c1_ale",   ale[0],      1);
    check("rd_c1_paddr", pin_addr[0], 7'h05);
    check("rd_c1_oe",    bus_oe[0],   0);
    step();
    check("rd_c2_ale",   ale[0],      0);
    check("rd_c2_paddr", pin_addr[0], 7'h25);
    step();
    check("rd_c3_busy",  busy[0],     1);
    check("rd_c3_paddr", pin_addr[0], 7'h25);
    check("rd_c3_ack",   ack[0],      0);
    step();
    check("rd_c4_oe",    bus_oe[0],   0);
    check("rd_c4_we",    pin_we[0],   0);
    check("rd_c4_ack",   ack[0],      0);
    step();
    check("rd_c5_ack",   ack[0],      1);
    check("rd_c5_dout",  cpu_dout[0], 8'h3C);
    check("rd_c5_paddr", pin_addr[0], 0);
    req[0] = 1'b0;
    step();

    // External write with no wait states on u1
    addr = 10'h07F; wdata = 8'hA5; we = 1'b1; req[1] = 1'b1;
    step();
    check("wr_c1_ale",   ale[1],      1);
    check("wr_c1_paddr", pin_addr[1], 7'h00);
    check("wr_c1_oe",    bus_oe[1],   0);
    step();
    check("wr_c2_paddr", pin_addr[1], 7'h7F);
    check("wr_c2_we",    pin_we[1],   0);
    step();
    check("wr_c3_we",    pin_we[1],   1);
    check("wr_c3_oe",    bus_oe[1],   8'hFF);
    check("wr_c3_bdata", bus_dout[1], 8'hA5);
    check("wr_c3_paddr", pin_addr[1], 7'h7F);
    step();
    check("wr_c4_ack",   ack[1],      1);
    check("wr_c4_we",    pin_we[1],   0);
    check("wr_c4_oe",    bus_oe[1],   0);
    req[1] = 1'b0;
    step();

    // ROM read on u0
    rom_en = 1'b1; addr = 10'h013; we = 1'b0; rom_data = 8'h9E; req[0] = 1'b1;
    step();
    check("rom_c1_raddr", rom_addr[0], 5'h13);
    check("rom_c1_ale",   ale[0],      0);
    check("rom_c1_paddr", pin_addr[0], 0);
    check("rom_c1_busy",  busy[0],     1);
    step();
    check("rom_c2_ack",   ack[0],      1);
    check("rom_c2_dout",  cpu_dout[0], 8'h9E);
    req[0] = 1'b0;
    step();

    // Boundary: 0x020 is just outside the ROM window -> external read
    addr = 10'h020; bus_din = 8'h5A; req[0] = 1'b1;
    step();
    check("bnd_c1_ale",   ale[0],      1);
    check("bnd_c1_paddr", pin_addr[0], 7'h00);
    check("bnd_c1_raddr", rom_addr[0], 0);
    step();
    check("bnd_c2_paddr", pin_addr[0], 7'h20);
    step();
    step();
    step();
    check("bnd_c5_ack",  ack[0],      1);
    check("bnd_c5_dout", cpu_dout[0], 8'h5A);
    req[0] = 1'b0;
    step();

    // ROM write to 0x01F: dropped, acked in cycle 2, no pin activity
    addr = 10'h01F; we = 1'b1; wdata = 8'h11; req[0] = 1'b1;
    step();
    check("romw_c1_we",    pin_we[0],   0);
    check("romw_c1_oe",    bus_oe[0],   0);
    check("romw_c1_raddr", rom_addr[0], 5'h1F);
    step();
    check("romw_c2_ack",  ack[0],      1);
    check("romw_c2_we",   pin_we[0],   0);
    check("romw_c2_dout", cpu_dout[0], 8'h5A);
    req[0] = 1'b0;
    step();

    // Reset mid-write: reset asserted while u0 is in WAIT
    rom_en = 1'b0; addr = 10'h155; we = 1'b1; wdata = 8'h77; req[0] = 1'b1;
    step();
    step();
    step();
    check("rstw_wait_busy", busy[0], 1);
    check("rstw_wait_we",   pin_we[0], 0);
    rst = 1'b1; req[0] = 1'b0;
    step();
    rst = 1'b0;
    check("rstw_busy",  busy[0],     0);
    check("rstw_we",    pin_we[0],   0);
    check("rstw_oe",    bus_oe[0],   0);
    check("rstw_paddr", pin_addr[0], 0);
    check("rstw_dout",  cpu_dout[0], 0);
    check("rstw_ack",   ack[0],      0);
    step();
    check("rstw_after_we",  pin_we[0], 0);
    check("rstw_after_ack", ack[0],    0);
    step();

    // Back-to-back on u0 with cpu_req held high
    addr = 10'h2A5; we = 1'b0; bus_din = 8'h3C; req[0] = 1'b1;
    step();
    step();
    step();
    step();
    step();
    check("b2b_ack1",    ack[0],  1);
    step();
    check("b2b_idle",    busy[0], 0);
    step();
    check("b2b_restart", busy[0], 1);
    check("b2b_re_ale",  ale[0],  1);
    req[0] = 1'b0;
    step();
    step();
    step();
    check("b2b_pre_ack2", ack[0], 0);
    step();
    check("b2b_ack2",     ack[0], 1);
    step();
    check("b2b_done",     busy[0], 0);

    // Back-to-back on u2: single-phase address, three wait states, ack at 6
    addr = 10'h045; we = 1'b0; bus_din = 8'hC3; req[2] = 1'b1;
    step();
    check("sp_c1_ale",   ale[2],      0);
    check("sp_c1_paddr", pin_addr[2], 7'h45);
    check("sp_c1_busy",  busy[2],     1);
    step();
    step();
    step();
    check("sp_c4_paddr", pin_addr[2], 7'h45);
    step();
    check("sp_c5_ack",   ack[2],      0);
    step();
    check("sp_c6_ack",   ack[2],      1);
    check("sp_c6_dout",  cpu_dout[2], 8'hC3);
    step();
    check("sp_idle",     busy[2],     0);
    step();
    check("sp_restart",  busy[2],     1);
    check("sp_re_paddr", pin_addr[2], 7'h45);
    req[2] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("sp_pre_ack2", ack[2], 0);
    step();
    check("sp_ack2",     ack[2], 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
